// File: rtl/inst_mem_sp.sv
// ============================================================================
// Module   : inst_mem_sp
// Purpose  : Single-port instruction memory, NOP-cleared after every reset,
//            with a registered fetch port and a word-wide load port.
//            Optional macro: IMEM_MISALIGN_TRAP_EN (misaligned fetch -> NOP + err)
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_mem_sp #(
   parameter int              DW  = 32,
   parameter int              AW  = 5,
   parameter logic [DW-1:0]   NOP = 32'h0000_0013
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              ready_o,
   input  logic              fetch_req_i,
   input  logic [AW+1:0]     fetch_addr_i,
   output logic              fetch_valid_o,
   output logic [DW-1:0]     fetch_data_o,
   output logic              fetch_err_o,
   input  logic              ld_en_i,
   input  logic [AW-1:0]     ld_addr_i,
   input  logic [DW-1:0]     ld_data_i,
   output logic              ld_done_o
);

   localparam int c_DEPTH = 2**AW;

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_cnt;
   logic              r_ready;
   logic              r_valid;
   logic [DW-1:0]     r_data;
   logic              r_done;
   logic [DW-1:0]     r_mem [0:c_DEPTH-1];

   logic              w_we;
   logic [AW-1:0]     w_waddr;
   logic [DW-1:0]     w_wdata;
   logic [AW-1:0]     w_fidx;
   logic              w_misalign;

   assign w_fidx     = fetch_addr_i[AW+1:2];
   assign w_misalign = |fetch_addr_i[1:0];

   // Clear writes and load writes share the single write port; reset blocks both.
   assign w_we    = !rst_i && ((r_state == S_INIT) || ld_en_i);
   assign w_waddr = (r_state == S_INIT) ? r_cnt : ld_addr_i;
   assign w_wdata = (r_state == S_INIT) ? NOP   : ld_data_i;

   always_ff @(posedge clk_i) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

`ifdef IMEM_MISALIGN_TRAP_EN
   logic r_err;
`else
   logic w_unused_misalign;
   assign w_unused_misalign = w_misalign;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_done  <= 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_INIT: begin
               r_cnt   <= r_cnt + 1'b1;
               r_valid <= 1'b0;
               r_data  <= '0;
               r_done  <= 1'b0;
`ifdef IMEM_MISALIGN_TRAP_EN
               r_err   <= 1'b0;
`endif
               if (r_cnt == {AW{1'b1}}) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_valid <= fetch_req_i;
               r_done  <= ld_en_i;
               // Array read sees pre-edge contents, giving read-first behaviour.
`ifdef IMEM_MISALIGN_TRAP_EN
               r_err   <= fetch_req_i && w_misalign;
               if (!fetch_req_i)    r_data <= '0;
               else if (w_misalign) r_data <= NOP;
               else                 r_data <= r_mem[w_fidx];
`else
               r_data  <= fetch_req_i ? r_mem[w_fidx] : '0;
`endif
            end
         endcase
      end
   end

   assign ready_o       = r_ready;
   assign fetch_valid_o = r_valid;
   assign fetch_data_o  = r_data;
   assign ld_done_o     = r_done;
`ifdef IMEM_MISALIGN_TRAP_EN
   assign fetch_err_o   = r_err;
`else
   assign fetch_err_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/inst_mem_sp.md
# inst_mem_sp

Parametrised single-clock instruction memory for the RISC-V core, the successor to the fixed 32-entry test instruction store. It provides a byte-addressed fetch port with a one-cycle registered read and a valid handshake, plus a word-wide load port used by the testbench or boot logic to write programs. After every reset it runs a clear sequence that fills the array with NOP before accepting traffic. It sits between the fetch stage and the program loader.

## Interface
- `DW`, 32, data/instruction width in bits; multiple of 8.
- `AW`, 5, word-address width; depth = 2**AW words.
- `NOP`, 32'h0000_0013, fill value (ADDI x0,x0,0) for clear and for error responses.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `ready_o`  out  1  high once the clear sequence is complete.
- `fetch_req_i`  in  1  fetch request.
- `fetch_addr_i`  in  AW+2  byte address.
- `fetch_valid_o`  out  1  response valid, one cycle after an accepted request.
- `fetch_data_o`  out  DW  fetched word.
- `fetch_err_o`  out  1  misaligned fetch flag; only with `IMEM_MISALIGN_TRAP_EN`, otherwise tied 0.
- `ld_en_i`  in  1  load-port write enable.
- `ld_addr_i`  in  AW  word address for load.
- `ld_data_i`  in  DW  load data.
- `ld_done_o`  out  1  pulses one cycle after an accepted load write.

## Operation
- Two states: `INIT` and `RUN`. Reset forces `INIT` with clear counter = 0.
- `INIT`:
  - Each cycle writes `NOP` to word[counter], then increments the counter.
  - When counter = 2**AW-1 is written, the next state is `RUN`. Duration is exactly 2**AW cycles.
  - `ready_o`=0. Fetch requests and load writes are ignored: no valid, no done, no write.
- `RUN`:
  - `ready_o`=1.
  - A fetch is accepted when `fetch_req_i`=1. The word index is `fetch_addr_i[AW+1:2]`.
  - A load is accepted when `ld_en_i`=1. It writes `ld_data_i` to word[`ld_addr_i`].
  - Fetch and load are independent and may occur in the same cycle.
  - Same-cycle fetch and load to the same word is read-first: the fetch returns the old contents.
- Address wrap: byte addresses are taken modulo 2**(AW+2). There is no out-of-range condition.
- Reset in any state or mid-transaction:
  - Outputs go to their reset values next edge.
  - Any pending response is dropped.
  - `INIT` restarts from counter 0, and the whole array is re-cleared.
- Output reset values: `ready_o`=0, `fetch_valid_o`=0, `fetch_data_o`=0, `fetch_err_o`=0, `ld_done_o`=0.

## Timing
- Fetch latency is 1 cycle. A request accepted at edge N gives `fetch_valid_o`=1 with data during cycle N+1.
- Back-to-back requests give one response per cycle, with no bubbles.
- `fetch_valid_o` is high only for cycles following an accepted request.
- When `fetch_valid_o`=0, `fetch_data_o` is driven to 0. It never holds stale data.
- Load write takes effect at edge N. A fetch of that word accepted at edge N+1 or later returns the new data. `ld_done_o` is high during cycle N+1.
- `ready_o` rises during the cycle after the last clear write, i.e. 2**AW edges after the reset edge is released.

## Configuration
- `IMEM_MISALIGN_TRAP_EN` defined:
  - A fetch with `fetch_addr_i[1:0]`≠0 still produces `fetch_valid_o`=1 with the same latency.
  - `fetch_data_o`=`NOP` and `fetch_err_o`=1 in that response cycle. The array is not read.
  - Aligned fetches give `fetch_err_o`=0.
- Not defined: `fetch_addr_i[1:0]` is ignored, and `fetch_err_o` is constantly 0.

## Test plan
- Reset with AW=5: hold `rst_i` 1 cycle -> `ready_o`=0 for 32 cycles then 1; fetch of byte addr 0x7C -> 32'h0000_0013.
- Load word 3 = 32'h0020_8193, then fetch byte addr 0x0C on the next cycle -> `fetch_valid_o` 1 cycle later with 32'h0020_8193; `ld_done_o` pulses once.
- Same cycle: load word 5 = 32'hDEAD_BEEF and fetch addr 0x14 -> response is old value (NOP); a second fetch -> 32'hDEAD_BEEF.
- Streaming: fetches 0x00,0x04,0x08 on consecutive cycles after loading 1,2,3 -> valid high 3 consecutive cycles, data 1,2,3 in order.
- With `IMEM_MISALIGN_TRAP_EN`: fetch 0x06 -> valid=1, err=1, data=NOP. Without it: fetch 0x06 -> word 1, err=0.
- Assert `rst_i` during a streaming fetch: valid=0 next cycle; loaded data is gone; after 32 cycles, fetch of 0x0C -> NOP.
